// File: rtl/sym_fir_pkg.sv
// Shared types and helpers for the time-multiplexed symmetric FIR filter.
// Holds the FSM state type, the derived-width helpers and the round/saturate stage.
package sym_fir_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MAC   = 3'd2,
        ROUND = 3'd3,
        OUT   = 3'd4
    } state_t;

    function automatic int calc_ca_w(input int tap_half);
        return (tap_half > 1) ? $clog2(tap_half) : 1;
    endfunction

    function automatic int calc_acc_w(input int data_w, input int coeff_w, input int ca_w);
        return data_w + 1 + coeff_w + ca_w;
    endfunction

    // Round half up, shift arithmetically, then clip to a signed data_w range.
    function automatic logic signed [63:0] round_sat(
        input  logic signed [63:0] acc,
        input  int                 data_w,
        input  int                 out_shift,
        output logic               sat
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r   = (out_shift > 0) ? ((acc + (64'sd1 <<< (out_shift - 1))) >>> out_shift) : acc;
        hi  = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (data_w - 1));
        sat = 1'b0;
        if (r > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            r   = lo;
            sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sym_fir_hist.sv
// Per-channel sample histories: shift-in write port and two combinational read ports.
// Slot 0 holds the newest sample, slot NUM_TAPS-1 the oldest.
module sym_fir_hist #(
    parameter int DATA_W   = 24,
    parameter int NUM_TAPS = 101,
    parameter int NUM_CH   = 2,
    parameter int CH_W     = 1,
    parameter int IDX_W    = $clog2(NUM_TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     shift_en,
    input  logic [CH_W-1:0]          shift_ch,
    input  logic signed [DATA_W-1:0] shift_data,
    input  logic [CH_W-1:0]          rd_ch,
    input  logic [IDX_W-1:0]         rd_idx_a,
    input  logic [IDX_W-1:0]         rd_idx_b,
    output logic signed [DATA_W-1:0] rd_a,
    output logic signed [DATA_W-1:0] rd_b
);

    logic signed [DATA_W-1:0] mem [NUM_CH][NUM_TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int i = 0; i < NUM_TAPS; i++) begin
                    mem[c][i] <= '0;
                end
            end
        end else if (shift_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (shift_ch == CH_W'(c)) begin
                    mem[c][0] <= shift_data;
                    for (int i = 1; i < NUM_TAPS; i++) begin
                        mem[c][i] <= mem[c][i-1];
                    end
                end
            end
        end
    end

    assign rd_a = mem[rd_ch][rd_idx_a];
    assign rd_b = mem[rd_ch][rd_idx_b];

endmodule

// File: rtl/sym_fir_mc.sv
// Multi-channel symmetric FIR: one pre-adder and one MAC serialised over the half-taps,
// with a runtime-writable coefficient bank and round/saturate output scaling.
module sym_fir_mc
    import sym_fir_pkg::*;
#(
    parameter  int DATA_W    = 24,
    parameter  int COEFF_W   = 16,
    parameter  int NUM_TAPS  = 101,
    parameter  int NUM_CH    = 2,
    parameter  int OUT_SHIFT = 15,
    localparam int TAP_HALF  = (NUM_TAPS + 1) / 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CA_W      = calc_ca_w(TAP_HALF),
    localparam int ACC_W     = calc_acc_w(DATA_W, COEFF_W, CA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CH_W-1:0]    in_ch,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CH_W-1:0]    out_ch,
    output logic               out_sat,
    input  logic               coef_we,
    input  logic [CA_W-1:0]    coef_addr,
    input  logic [COEFF_W-1:0] coef_wdata,
    output logic               busy
);

    localparam int IDX_W = $clog2(NUM_TAPS);
    localparam logic [CA_W-1:0] K_LAST = CA_W'(TAP_HALF - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready and out_valid are decoded from the state register only.
    state_t state, state_nxt;

    logic signed [COEFF_W-1:0] coef [TAP_HALF];
    logic signed [DATA_W-1:0]  sample;
    logic [CH_W-1:0]           ch_q;
    logic [CA_W-1:0]           k;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DATA_W-1:0]  x_a, x_b;
    logic signed [DATA_W:0]    pre;
    logic signed [COEFF_W-1:0] coef_k;
    logic signed [DATA_W+COEFF_W:0] prod;
    logic signed [63:0]        acc_ext;
    logic [DATA_W-1:0]         rs_data;
    logic                      rs_sat;
    logic                      ch_ok;
    logic                      k_last;

    assign ch_ok  = {1'b0, ch_q} < (CH_W + 1)'(NUM_CH);
    assign k_last = (k == K_LAST);

    sym_fir_hist #(
        .DATA_W   (DATA_W),
        .NUM_TAPS (NUM_TAPS),
        .NUM_CH   (NUM_CH),
        .CH_W     (CH_W),
        .IDX_W    (IDX_W)
    ) u_hist (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en   ((state == LOAD) && ch_ok),
        .shift_ch   (ch_q),
        .shift_data (sample),
        .rd_ch      (ch_q),
        .rd_idx_a   (IDX_W'(k)),
        .rd_idx_b   (IDX_W'(NUM_TAPS - 1) - IDX_W'(k)),
        .rd_a       (x_a),
        .rd_b       (x_b)
    );

    // Centre tap is used once; every other step folds the mirrored pair.
    always_comb begin
        pre = {x_a[DATA_W-1], x_a};
        if (!k_last) begin
            pre = {x_a[DATA_W-1], x_a} + {x_b[DATA_W-1], x_b};
        end
    end

    assign coef_k  = coef[k];
    assign prod    = pre * coef_k;
    assign acc_ext = 64'(acc);

    always_comb begin
        rs_sat  = 1'b0;
        rs_data = DATA_W'(round_sat(acc_ext, DATA_W, OUT_SHIFT, rs_sat));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = LOAD;
            LOAD:    state_nxt = ch_ok ? MAC : IDLE;
            MAC:     if (k_last) state_nxt = ROUND;
            ROUND:   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAP_HALF; i++) coef[i] <= '0;
            sample   <= '0;
            ch_q     <= '0;
            k        <= '0;
            acc      <= '0;
            out_data <= '0;
            out_ch   <= '0;
            out_sat  <= 1'b0;
        end else begin
            // A write in the accepting IDLE cycle lands before MAC reads the bank.
            if (coef_we && (state == IDLE) && ({1'b0, coef_addr} < (CA_W + 1)'(TAP_HALF))) begin
                coef[coef_addr] <= coef_wdata;
            end
            case (state)
                IDLE: if (in_valid) begin
                    sample <= in_data;
                    ch_q   <= in_ch;
                end
                LOAD: begin
                    acc <= '0;
                    k   <= '0;
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (!k_last) k <= k + 1'b1;
                end
                ROUND: begin
                    out_data <= rs_data;
                    out_sat  <= rs_sat;
                    out_ch   <= ch_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sym_fir_mc.sv
// Directed bench for sym_fir_mc with 5 taps and 2 channels; expected values are hand-derived.
module tb_sym_fir_mc;

    localparam int DATA_W    = 24;
    localparam int COEFF_W   = 16;
    localparam int NUM_TAPS  = 5;
    localparam int NUM_CH    = 2;
    localparam int OUT_SHIFT = 15;
    localparam int TAP_HALF  = 3;
    localparam int CH_W      = 1;
    localparam int CA_W      = 2;
    // out_valid is visible in the (TAP_HALF+3)th cycle after the accepting edge.
    localparam int LAT_EDGES = TAP_HALF + 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [CH_W-1:0]    in_ch;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [CH_W-1:0]    out_ch;
    logic               out_sat;
    logic               coef_we;
    logic [CA_W-1:0]    coef_addr;
    logic [COEFF_W-1:0] coef_wdata;
    logic               busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int lat = 0;

    logic [DATA_W-1:0] imp_exp [5];

    sym_fir_mc #(
        .DATA_W    (DATA_W),
        .COEFF_W   (COEFF_W),
        .NUM_TAPS  (NUM_TAPS),
        .NUM_CH    (NUM_CH),
        .OUT_SHIFT (OUT_SHIFT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ch      (in_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_sat    (out_sat),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] d);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("send_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_ch    = ch;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic send_coef(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] d,
                             input logic [CA_W-1:0] a, input logic [COEFF_W-1:0] v);
        @(negedge clk);
        check("sendc_in_ready", in_ready, 1);
        in_valid   = 1'b1;
        in_ch      = ch;
        in_data    = d;
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        lat = cyc - acc_cyc;
    endtask

    task automatic recv(input string tag, input logic [DATA_W-1:0] ed,
                        input logic [CH_W-1:0] ec, input logic es);
        wait_valid();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, ed);
        check({tag, "_ch"}, out_ch, ec);
        check({tag, "_sat"}, out_sat, es);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coef(input logic [CA_W-1:0] a, input logic [COEFF_W-1:0] v);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = v;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    initial begin
        imp_exp[0] = 24'd1024;
        imp_exp[1] = 24'd2048;
        imp_exp[2] = 24'd4096;
        imp_exp[3] = 24'd2048;
        imp_exp[4] = 24'd1024;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ch = '0;
        out_ready = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_sat", out_sat, 0);

        wr_coef(2'd0, 16'd1024);
        wr_coef(2'd1, 16'd2048);
        wr_coef(2'd2, 16'd4096);
        wr_coef(2'd3, 16'd5000);

        // Impulse on ch0, including first-output latency.
        send(1'b0, 24'd32768);
        recv("imp0", imp_exp[0], 1'b0, 1'b0);
        check("latency", lat, LAT_EDGES);
        for (int i = 1; i < 5; i++) begin
            send(1'b0, 24'd0);
            recv("imp", imp_exp[i], 1'b0, 1'b0);
        end

        // Impulse on ch1 interleaved with zeros on ch0.
        for (int i = 0; i < 5; i++) begin
            send(1'b1, (i == 0) ? 24'd32768 : 24'd0);
            recv("iso_ch1", imp_exp[i], 1'b1, 1'b0);
            send(1'b0, 24'd0);
            recv("iso_ch0", 24'd0, 1'b0, 1'b0);
        end

        // Backpressure: output held for 20 cycles.
        out_ready = 1'b0;
        send(1'b0, 24'd32768);
        wait_valid();
        for (int i = 0; i < 20; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 24'd1024);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_valid_drop", out_valid, 0);
        check("bp_in_ready_back", in_ready, 1);
        for (int i = 1; i < 5; i++) begin
            send(1'b0, 24'd0);
            recv("bp_flush", imp_exp[i], 1'b0, 1'b0);
        end

        // Coefficient write during MAC is discarded.
        send(1'b0, 24'd32768);
        @(posedge clk);
        #1;
        check("busy_at_wr", busy, 1);
        wr_coef(2'd2, 16'd0);
        recv("cwb", imp_exp[0], 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            send(1'b0, 24'd0);
            recv("cwb", imp_exp[i], 1'b0, 1'b0);
        end

        // Coefficient write in the accepting cycle applies to that sample.
        send_coef(1'b0, 24'd32768, 2'd0, 16'd2048);
        recv("cws0", 24'd2048, 1'b0, 1'b0);
        send(1'b0, 24'd0); recv("cws1", 24'd2048, 1'b0, 1'b0);
        send(1'b0, 24'd0); recv("cws2", 24'd4096, 1'b0, 1'b0);
        send(1'b0, 24'd0); recv("cws3", 24'd2048, 1'b0, 1'b0);
        send(1'b0, 24'd0); recv("cws4", 24'd2048, 1'b0, 1'b0);

        // Saturation at both rails, with unsaturated near-rail results in between.
        for (int i = 0; i < 3; i++) wr_coef(CA_W'(i), 16'd32767);
        send(1'b0, 24'h7FFFFF); recv("satp0", 24'h7FFEFF, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            send(1'b0, 24'h7FFFFF);
            recv("satp", 24'h7FFFFF, 1'b0, 1'b1);
        end
        send(1'b0, 24'h800000); recv("satn0", 24'h7FFFFF, 1'b0, 1'b1);
        send(1'b0, 24'h800000); recv("satn1", 24'h7FFEFD, 1'b0, 1'b0);
        send(1'b0, 24'h800000); recv("satn2", 24'h8000FE, 1'b0, 1'b0);
        send(1'b0, 24'h800000); recv("satn3", 24'h800000, 1'b0, 1'b1);
        send(1'b0, 24'h800000); recv("satn4", 24'h800000, 1'b0, 1'b1);

        // Reset in the middle of MAC.
        send(1'b0, 24'd32768);
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 24'd32768);
        recv("post_rst", 24'd0, 1'b0, 1'b0);
        send(1'b0, 24'd0);
        recv("post_rst1", 24'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
